// File: rtl/hb_out_buffer_if.sv
// Handshake bundle between the decimator cascade, hb_out_buffer and its consumer.
// slave = buffer side, master = cascade/consumer side.
interface hb_out_buffer_if #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 16,
   parameter int AW    = 3
);
   logic [IN_W-1:0]  din;
   logic             din_vld;
   logic [OUT_W-1:0] dout;
   logic             dout_vld;
   logic             dout_rdy;
   logic [AW:0]      level;
   logic             ovf;
   logic             sat;
   logic             flag_clr;

   modport master (
      output din, din_vld, dout_rdy, flag_clr,
      input  dout, dout_vld, level, ovf, sat
   );

   modport slave (
      input  din, din_vld, dout_rdy, flag_clr,
      output dout, dout_vld, level, ovf, sat
   );
endinterface

// File: rtl/hb_out_buffer.sv
// Round/saturate IN_W->OUT_W then queue in a fall-through FIFO; 2-cycle din_vld->dout_vld latency.
// No back-pressure to the cascade: a sample arriving while full (without a pop) is dropped and flags ovf.
module hb_out_buffer #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input logic            clk,
   input logic            reset,
   hb_out_buffer_if.slave bus
);
   localparam int SH = IN_W - OUT_W;
   localparam logic [IN_W:0]    RND   = (IN_W+1)'(1) << (SH - 1);
   localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [AW:0]      FULL  = (AW+1)'(DEPTH);

   logic             rv_q, rv_d;
   logic [OUT_W-1:0] r_q, r_d;
   logic [OUT_W-1:0] mem_q [DEPTH];
   logic [OUT_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             ovf_q, ovf_d;
   logic             sat_q, sat_d;

   logic [IN_W:0]    t;
   logic [OUT_W:0]   r_full;
   logic             clip;
   logic [OUT_W-1:0] r_sat;
   logic             pop;
   logic             wr;

   always_comb begin
      t      = {bus.din[IN_W-1], bus.din} + RND;
      r_full = (OUT_W+1)'($signed(t) >>> SH);
      // r_full is one bit wider than the output; disagreeing top bits mean out of range.
      clip   = r_full[OUT_W] ^ r_full[OUT_W-1];
      if (!clip)
         r_sat = r_full[OUT_W-1:0];
      else if (r_full[OUT_W])
         r_sat = S_MIN;
      else
         r_sat = S_MAX;
   end

   assign pop = (level_q != '0) && bus.dout_rdy;
   assign wr  = rv_q && ((level_q != FULL) || pop);

   always_comb begin
      rv_d     = bus.din_vld;
      r_d      = bus.din_vld ? r_sat : r_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr) begin
         mem_d[wr_ptr_q] = r_q;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      // A new event outranks a clear landing in the same cycle.
      ovf_d = (ovf_q && !bus.flag_clr) || (rv_q && !wr);
      sat_d = (sat_q && !bus.flag_clr) || (bus.din_vld && clip);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rv_q     <= 1'b0;
         r_q      <= '0;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         rv_q     <= rv_d;
         r_q      <= r_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         sat_q    <= sat_d;
      end
   end

   assign bus.dout     = mem_q[rd_ptr_q];
   assign bus.dout_vld = (level_q != '0);
   assign bus.level    = level_q;
   assign bus.ovf      = ovf_q;
   assign bus.sat      = sat_q;
endmodule

// File: tb/tb_hb_out_buffer.sv
// Directed bench for hb_out_buffer: rounding, saturation, fill/overflow, full read+write,
// streaming latency and asynchronous mid-operation reset.
module tb_hb_out_buffer;
   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   hb_out_buffer_if #(.IN_W(20), .OUT_W(16), .AW(3)) bus ();

   hb_out_buffer #(.IN_W(20), .OUT_W(16), .DEPTH(8), .AW(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One sample with the consumer ready: checks the 2-cycle latency, value and drain.
   task automatic push_expect(input string tag, input logic [19:0] v, input logic [15:0] exp);
      bus.din     = v;
      bus.din_vld = 1'b1;
      tick();
      bus.din_vld = 1'b0;
      check({tag, "_vld_early"}, 32'(bus.dout_vld), 32'd0);
      tick();
      check({tag, "_vld"}, 32'(bus.dout_vld), 32'd1);
      check({tag, "_dout"}, 32'(bus.dout), 32'(exp));
      tick();
      check({tag, "_level"}, 32'(bus.level), 32'd0);
   endtask

   initial begin
      n_assert     = 0;
      n_fail       = 0;
      reset        = 1'b1;
      bus.din      = '0;
      bus.din_vld  = 1'b0;
      bus.dout_rdy = 1'b0;
      bus.flag_clr = 1'b0;
      #3;
      check("rst_dout",  32'(bus.dout),     32'd0);
      check("rst_vld",   32'(bus.dout_vld), 32'd0);
      check("rst_level", 32'(bus.level),    32'd0);
      check("rst_ovf",   32'(bus.ovf),      32'd0);
      check("rst_sat",   32'(bus.sat),      32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Rounding (half up)
      bus.dout_rdy = 1'b1;
      push_expect("rnd_p8", 20'h00008, 16'h0001);
      push_expect("rnd_p7", 20'h00007, 16'h0000);
      push_expect("rnd_m8", 20'hFFFF8, 16'h0000);
      push_expect("rnd_m9", 20'hFFFF7, 16'hFFFF);
      check("rnd_sat", 32'(bus.sat), 32'd0);

      // Saturation and sticky sat
      push_expect("sat_pos", 20'h7FFF8, 16'h7FFF);
      check("sat_set", 32'(bus.sat), 32'd1);
      bus.flag_clr = 1'b1;
      tick();
      bus.flag_clr = 1'b0;
      check("sat_clr", 32'(bus.sat), 32'd0);
      push_expect("sat_neg", 20'h80000, 16'h8000);
      check("sat_neg_noclip", 32'(bus.sat), 32'd0);
      bus.flag_clr = 1'b1;
      bus.din      = 20'h7FFF8;
      bus.din_vld  = 1'b1;
      tick();
      bus.flag_clr = 1'b0;
      bus.din_vld  = 1'b0;
      check("sat_set_wins", 32'(bus.sat), 32'd1);
      tick();
      tick();
      check("sat_drain", 32'(bus.level), 32'd0);
      bus.flag_clr = 1'b1;
      tick();
      bus.flag_clr = 1'b0;

      // Fill past full: 9th sample is dropped
      bus.dout_rdy = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         bus.din     = 20'(i * 16);
         bus.din_vld = 1'b1;
         tick();
      end
      bus.din_vld = 1'b0;
      tick();
      check("fill_level", 32'(bus.level), 32'd8);
      check("fill_ovf",   32'(bus.ovf),   32'd1);
      bus.dout_rdy = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain_dout%0d", i), 32'(bus.dout), 32'(i));
         tick();
      end
      check("drain_level", 32'(bus.level),    32'd0);
      check("drain_vld",   32'(bus.dout_vld), 32'd0);
      bus.dout_rdy = 1'b0;
      bus.flag_clr = 1'b1;
      tick();
      bus.flag_clr = 1'b0;
      check("ovf_clr", 32'(bus.ovf), 32'd0);

      // Full with simultaneous write and pop
      for (int i = 1; i <= 8; i++) begin
         bus.din     = 20'(i * 16);
         bus.din_vld = 1'b1;
         tick();
      end
      bus.din_vld = 1'b0;
      tick();
      check("full_level", 32'(bus.level), 32'd8);
      bus.din     = 20'd144;
      bus.din_vld = 1'b1;
      tick();
      bus.din_vld  = 1'b0;
      bus.dout_rdy = 1'b1;
      tick();
      bus.dout_rdy = 1'b0;
      check("rw_level", 32'(bus.level), 32'd8);
      check("rw_ovf",   32'(bus.ovf),   32'd0);
      bus.dout_rdy = 1'b1;
      for (int i = 2; i <= 9; i++) begin
         check($sformatf("rw_dout%0d", i), 32'(bus.dout), 32'(i));
         tick();
      end
      check("rw_empty", 32'(bus.level), 32'd0);

      // Streaming: one sample per cycle, consumer always ready
      for (int c = 0; c < 13; c++) begin
         bus.din_vld = (c < 10);
         bus.din     = 20'((c + 1) * 16);
         tick();
         check($sformatf("strm_level%0d", c), 32'(bus.level <= 4'd1), 32'd1);
         if (c >= 1 && c <= 10) begin
            check($sformatf("strm_vld%0d", c),  32'(bus.dout_vld), 32'd1);
            check($sformatf("strm_dout%0d", c), 32'(bus.dout),     32'(c));
         end else if (c > 10) begin
            check($sformatf("strm_idle%0d", c), 32'(bus.dout_vld), 32'd0);
         end
      end
      bus.din_vld = 1'b0;
      check("strm_ovf", 32'(bus.ovf), 32'd0);

      // Asynchronous reset with samples queued
      bus.dout_rdy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         bus.din     = 20'(i * 16 + 16'h100);
         bus.din_vld = 1'b1;
         tick();
      end
      bus.din_vld = 1'b0;
      tick();
      check("mid_level", 32'(bus.level), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_dout",  32'(bus.dout),     32'd0);
      check("mid_rst_vld",   32'(bus.dout_vld), 32'd0);
      check("mid_rst_level", 32'(bus.level),    32'd0);
      check("mid_rst_ovf",   32'(bus.ovf),      32'd0);
      check("mid_rst_sat",   32'(bus.sat),      32'd0);
      tick();
      reset = 1'b0;
      tick();
      bus.dout_rdy = 1'b1;
      push_expect("post_rst", 20'h00050, 16'h0005);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
